// File: rtl/ir_letter_scheduler.sv
// Letter path scheduler: circular FIFO over a dual-port letter BRAM feeding the IR transmitter.
// Optional busy-rise watchdog with retry enabled by defining IR_LETTER_SCHED_TIMEOUT_EN.
module ir_letter_scheduler #(
  parameter int DEPTH          = 1000,
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 2,
  parameter int GAP_CYCLES     = 100000,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              enc_valid_in,
  input  logic [4:0]        enc_data_in,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [4:0]        wr_data_out,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [4:0]        rd_data_in,
  output logic              tx_valid_out,
  output logic [4:0]        tx_data_out,
  input  logic              tx_busy_in,
  output logic [ADDR_W:0]   count_out,
  output logic              full_out,
  output logic              empty_out,
  output logic              overflow_out,
`ifdef IR_LETTER_SCHED_TIMEOUT_EN
  output logic              retry_out,
`endif
  output logic [2:0]        state_dbg_out
);

  localparam int CNT_W   = ADDR_W + 1;
  localparam int TMR_MAX = (GAP_CYCLES > TIMEOUT_CYCLES)
                         ? ((GAP_CYCLES > READ_LATENCY) ? GAP_CYCLES : READ_LATENCY)
                         : ((TIMEOUT_CYCLES > READ_LATENCY) ? TIMEOUT_CYCLES : READ_LATENCY);
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SEND, S_WAIT_RISE, S_WAIT_FALL, S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ADDR_W-1:0]  wr_ptr_q, rd_ptr_q, wr_addr_q;
  logic [4:0]         wr_data_q, tx_data_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wr_en_q, overflow_q, enc_armed_q;
  logic               enc_rise, full, empty, write_ok;
  logic               pop, latch, restore;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] ptr_dec(input logic [ADDR_W-1:0] p);
    return (p == '0) ? ADDR_W'(DEPTH - 1) : p - ADDR_W'(1);
  endfunction

  // enc_armed_q clears to 0, so a valid level held through reset release is not an edge.
  assign enc_rise = enc_valid_in & enc_armed_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign write_ok = enc_rise & ~full;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Handshake: tx_valid_out is a one-cycle strobe issued only after tx_busy_in was low at fetch
  // start; the transmitter accepts by raising tx_busy_in and finishes by dropping it.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: if (!empty && !tx_busy_in) begin
        state_d = S_FETCH;
        timer_d = TMR_W'(READ_LATENCY);
      end
      S_FETCH: if (timer_q == '0) state_d = S_SEND;
               else timer_d = timer_q - TMR_W'(1);
      S_SEND: begin
        state_d = S_WAIT_RISE;
        timer_d = TMR_W'(TIMEOUT_CYCLES - 1);
      end
      S_WAIT_RISE: begin
        if (tx_busy_in) state_d = S_WAIT_FALL;
`ifdef IR_LETTER_SCHED_TIMEOUT_EN
        else if (timer_q == '0) begin
          state_d = S_FETCH;
          timer_d = TMR_W'(READ_LATENCY);
        end else timer_d = timer_q - TMR_W'(1);
`endif
      end
      S_WAIT_FALL: if (!tx_busy_in) begin
        state_d = S_GAP;
        timer_d = TMR_W'(GAP_CYCLES - 1);
      end
      S_GAP: if (timer_q == '0) state_d = S_IDLE;
             else timer_d = timer_q - TMR_W'(1);
      default: state_d = S_IDLE;
    endcase
    if (flush_in) begin
      state_d = S_IDLE;
      timer_d = '0;
    end
  end

  always_comb begin
    tx_valid_out = (state_q == S_SEND) && !flush_in;
    pop          = (state_q == S_SEND);
    latch        = (state_q == S_FETCH) && (timer_q == '0);
    restore      = 1'b0;
`ifdef IR_LETTER_SCHED_TIMEOUT_EN
    restore      = (state_q == S_WAIT_RISE) && !tx_busy_in && (timer_q == '0);
`endif
  end

  // Full is judged on the registered count, so a pop in the same cycle does not make room.
  always_comb count_d = count_q + CNT_W'(write_ok) + CNT_W'(restore) - CNT_W'(pop);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      enc_armed_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      enc_armed_q <= ~enc_valid_in;
      if (flush_in) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        wr_addr_q  <= '0;
        wr_en_q    <= 1'b0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        wr_en_q <= write_ok;
        if (write_ok) begin
          wr_addr_q <= wr_ptr_q;
          wr_data_q <= enc_data_in;
          wr_ptr_q  <= ptr_inc(wr_ptr_q);
        end
        if (enc_rise && full) overflow_q <= 1'b1;
        if (pop)          rd_ptr_q <= ptr_inc(rd_ptr_q);
        else if (restore) rd_ptr_q <= ptr_dec(rd_ptr_q);
        count_q <= count_d;
        if (latch) tx_data_q <= rd_data_in;
      end
    end
  end

`ifdef IR_LETTER_SCHED_TIMEOUT_EN
  logic retry_q;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)       retry_q <= 1'b0;
    else if (flush_in) retry_q <= 1'b0;
    else if (restore)  retry_q <= 1'b1;
  end
  assign retry_out = retry_q;
`endif

  assign wr_addr_out   = wr_addr_q;
  assign wr_data_out   = wr_data_q;
  assign wr_en_out     = wr_en_q;
  assign rd_addr_out   = rd_ptr_q;
  assign tx_data_out   = tx_data_q;
  assign count_out     = count_q;
  assign full_out      = full;
  assign empty_out     = empty;
  assign overflow_out  = overflow_q;
  assign state_dbg_out = state_q;

endmodule

// File: doc/ir_letter_scheduler.md
Name: ir_letter_scheduler

Overview:
- Sequences the letter path: enigma output -> letter buffer BRAM (true dual-port, read-first, 1 clock) -> IR transmitter.
- Owns the BRAM write and read pointers as a circular FIFO and edge-detects the enigma valid level.
- Fetches each stored letter with fixed BRAM read latency, hands it to the IR transmitter with a valid/busy handshake, and enforces an inter-letter gap.
- Reports occupancy, full, empty and sticky overflow.

Parameters:
- DEPTH, 1000, buffer entries; pointers wrap DEPTH-1 -> 0.
- ADDR_W, 10, pointer/address width; must satisfy 2^ADDR_W >= DEPTH.
- READ_LATENCY, 2, BRAM port-B cycles from address to valid doutb (HIGH_PERFORMANCE).
- GAP_CYCLES, 100000, idle clk_in cycles after transmitter busy falls before the next fetch (1 ms at 100 MHz).
- TIMEOUT_CYCLES, 1000, busy-rise watchdog limit; used only with the optional feature.

Ports:
- clk_in  input  1  system clock (100 MHz domain).
- rst_in  input  1  reset, asynchronous assert, active-low.
- flush_in  input  1  synchronous clear of the buffer and scheduler.
- enc_valid_in  input  1  enigma data valid (level); rising edge = one new letter.
- enc_data_in  input  5  enigma letter 0-25.
- wr_addr_out  output  ADDR_W  BRAM port A address.
- wr_data_out  output  5  BRAM port A data.
- wr_en_out  output  1  BRAM port A write enable, one-cycle pulse.
- rd_addr_out  output  ADDR_W  BRAM port B address (= rd_ptr).
- rd_data_in  input  5  BRAM port B doutb.
- tx_valid_out  output  1  one-cycle letter strobe to the IR transmitter.
- tx_data_out  output  5  letter to the IR transmitter.
- tx_busy_in  input  1  IR transmitter busy.
- count_out  output  ADDR_W+1  stored letters not yet sent.
- full_out  output  1  count_out == DEPTH.
- empty_out  output  1  count_out == 0.
- overflow_out  output  1  sticky: a letter was dropped because the buffer was full.

Behaviour:
- Reset (rst_in low, async): wr_ptr=0, rd_ptr=0, count=0, state IDLE. All outputs 0 except empty_out=1. The edge-detect register clears to 0, so enc_valid_in held high through reset release does not produce a write.
- Write: on a rising edge of enc_valid_in, with !full:
  - wr_en_out=1 and wr_addr_out=wr_ptr for exactly one cycle; wr_data_out=enc_data_in registered on the same cycle.
  - wr_ptr advances, wrapping at DEPTH-1.
  - If full, the write is dropped: no wr_en_out, overflow_out<=1.
- Count: +1 on a write, -1 on a pop, unchanged if both occur in the same cycle. full_out and empty_out are derived from the registered count.
- FSM states: IDLE, FETCH, SEND, WAIT_RISE, WAIT_FALL, GAP.
  - IDLE: if count>0 and tx_busy_in==0, go to FETCH and load the latency counter.
  - FETCH: hold rd_addr_out for READ_LATENCY cycles, then latch rd_data_in into tx_data_out and go to SEND.
  - SEND: tx_valid_out=1 for one cycle; pop (rd_ptr++ with wrap, count-1); go to WAIT_RISE.
  - WAIT_RISE: wait for tx_busy_in==1, then go to WAIT_FALL.
  - WAIT_FALL: wait for tx_busy_in==0, load the gap counter, go to GAP.
  - GAP: count GAP_CYCLES, then go to IDLE.
- Latency: a write into an empty buffer gives tx_valid_out READ_LATENCY+2 cycles after wr_en_out. A letter written in cycle t is visible to a read from cycle t+1 (read-first BRAM; the FSM leaves IDLE no earlier than t+1).
- tx_data_out holds its value until the next SEND.
- flush_in (synchronous, takes priority over write and pop): pointers and count return to 0, FSM returns to IDLE, tx_valid_out=0, overflow_out cleared. A letter already accepted by the transmitter still completes in the transmitter.
- Wrap-around: after DEPTH writes and DEPTH pops, both pointers return to 0 and count=0.
- Simultaneous write and pop when full: the write is dropped, because full is evaluated before the pop.

Optional Feature:
- Macro: IR_LETTER_SCHED_TIMEOUT_EN.
- Defined: WAIT_RISE counts cycles. If tx_busy_in is not seen within TIMEOUT_CYCLES:
  - the FSM returns to FETCH for the same letter: rd_ptr is decremented with wrap and count is restored (+1);
  - a 1-bit sticky retry flag is set, exposed on port retry_out (output, 1, reset 0, cleared by flush_in).
- Not defined: WAIT_RISE waits indefinitely; retry_out is absent.

Test Plan:
- Reset with enc_valid_in held high, release rst_in -> no wr_en_out; empty_out=1, count_out=0.
- Write letter 7 to an empty buffer (busy model: rise 2 cycles after valid, 50 cycles high) -> wr_en_out at addr 0; tx_valid_out with tx_data_out=7 exactly 4 cycles later; next fetch not before busy-fall + GAP_CYCLES.
- Three writes 1,2,3 back-to-back (GAP_CYCLES=10) -> tx order 1,2,3; count_out sequence 3,2,1,0; rd_addr_out 0,1,2.
- DEPTH=4: write 5 letters with tx_busy_in held high -> 4 stored, full_out=1, overflow_out=1, fifth letter never transmitted; release busy -> 4 letters sent in order.
- DEPTH=4: stream 10 letters -> pointers wrap 3->0; all 10 letters received in order; empty_out=1 at end.
- flush_in during FETCH with count 2 -> no tx_valid_out; count_out=0, rd/wr pointers 0. With IR_LETTER_SCHED_TIMEOUT_EN and busy stuck low -> letter re-sent after TIMEOUT_CYCLES and retry_out=1.
